buzzer_player: RTL

Sound-output engine for the pet: the counterpart to the microphone listener. The listener turns incoming sound into a wake event; this block turns a request from the main pet FSM into an audible beep pattern on the buzzer. A request carries the current pet state code. The block plays a fixed number of beeps with state-dependent on/off lengths, then pulses `done`. It sits between the main FSM and the buzzer pin, which is active-low.

---
 rtl/buzzer_player_pkg.sv | 45 ++++
 rtl/buzzer_pattern_rom.sv | 23 ++
 rtl/buzzer_player.sv | 126 ++++++++++++
 3 files changed

// File: rtl/buzzer_player_pkg.sv
// Shared pet state codes, player FSM encoding and beep pattern payload.
package buzzer_player_pkg;

  localparam int unsigned PAT_W  = 4;
  localparam int unsigned BEEP_W = 2;
  localparam int unsigned TICK_W = 3;

  // Pet state codes shared with the main FSM and the microphone listener
  localparam logic [PAT_W-1:0] PET_IDLE   = 4'd0;
  localparam logic [PAT_W-1:0] PET_HAPPY  = 4'd1;
  localparam logic [PAT_W-1:0] PET_HUNGRY = 4'd2;
  localparam logic [PAT_W-1:0] PET_SLEEPY = 4'd3;
  localparam logic [PAT_W-1:0] PET_PLAY   = 4'd4;
  localparam logic [PAT_W-1:0] PET_SICK   = 4'd5;
  localparam logic [PAT_W-1:0] PET_DIRTY  = 4'd6;
  localparam logic [PAT_W-1:0] PET_BORED  = 4'd7;
  localparam logic [PAT_W-1:0] PET_WAKE   = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ON,
    ST_OFF,
    ST_DONE
  } player_state_t;

  // Beep count and on/off length (in ticks) for one pattern
  typedef struct packed {
    logic [BEEP_W-1:0] beeps;
    logic [TICK_W-1:0] ticks;
  } beep_cfg_t;

  // Counter width for a modulus of n, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic beep_cfg_t mk_cfg(input int unsigned b, input int unsigned t);
    beep_cfg_t c;
    c.beeps = BEEP_W'(b);
    c.ticks = TICK_W'(t);
    return c;
  endfunction

endpackage

// File: rtl/buzzer_pattern_rom.sv
// Pet state code to beep count / phase length lookup.
module buzzer_pattern_rom
  import buzzer_player_pkg::*;
(
  input  logic [PAT_W-1:0] pattern,
  output beep_cfg_t        cfg_c
);

  // Table lookup; unlisted codes fall back to two short beeps
  always_comb begin
    cfg_c = mk_cfg(2, 1);
    case (pattern)
      PET_IDLE, PET_HAPPY: cfg_c = mk_cfg(3, 2);
      PET_HUNGRY:          cfg_c = mk_cfg(1, 4);
      PET_SLEEPY:          cfg_c = mk_cfg(1, 2);
      PET_PLAY:            cfg_c = mk_cfg(2, 2);
      PET_SICK:            cfg_c = mk_cfg(2, 4);
      PET_WAKE:            cfg_c = mk_cfg(3, 1);
      default:             cfg_c = mk_cfg(2, 1);
    endcase
  end

endmodule

// File: rtl/buzzer_player.sv
// Beep pattern sequencer driving an active-low buzzer from a pet state request.
module buzzer_player
  import buzzer_player_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 6250000,
  parameter int unsigned TONE_HALF   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [PAT_W-1:0] pattern,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             buzzer
);

  localparam int unsigned CYC_W  = cnt_width(TICK_CYCLES);
  localparam int unsigned TONE_W = cnt_width(TONE_HALF + 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TICK_CYCLES - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
  localparam bit                TONE_EN   = (TONE_HALF > 0);

  player_state_t     state;
  logic [PAT_W-1:0]  pat_q;
  logic [BEEP_W-1:0] beep_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [TONE_W-1:0] tone_cnt;
  beep_cfg_t         cfg_c;
  logic              tick_wrap_c;
  logic              phase_end_c;

  buzzer_pattern_rom u_rom (
    .pattern (pat_q),
    .cfg_c   (cfg_c)
  );

  // Tick boundary and end of the current on/off phase
  always_comb begin
    tick_wrap_c = (cyc_cnt == CYC_LAST);
    phase_end_c = tick_wrap_c && (tick_cnt == TICK_W'(1));
  end

  // Sequencer: latch request, play ON/OFF phases per beep, report completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pat_q    <= '0;
      beep_cnt <= '0;
      tick_cnt <= '0;
      cyc_cnt  <= '0;
      tone_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      buzzer   <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && abort) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        buzzer <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req && !abort) begin
              pat_q <= pattern;
              busy  <= 1'b1;
              state <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            beep_cnt <= cfg_c.beeps;
            tick_cnt <= cfg_c.ticks;
            cyc_cnt  <= '0;
            tone_cnt <= '0;
            buzzer   <= 1'b0;
            state    <= ST_ON;
          end
          ST_ON: begin
            cyc_cnt <= tick_wrap_c ? '0 : cyc_cnt + CYC_W'(1);
            if (tick_wrap_c) tick_cnt <= tick_cnt - TICK_W'(1);
            if (phase_end_c) begin
              tick_cnt <= cfg_c.ticks;
              buzzer   <= 1'b1;
              state    <= ST_OFF;
            end else if (TONE_EN) begin
              if (tone_cnt == TONE_LAST) begin
                tone_cnt <= '0;
                buzzer   <= ~buzzer;
              end else begin
                tone_cnt <= tone_cnt + TONE_W'(1);
              end
            end
          end
          ST_OFF: begin
            cyc_cnt <= tick_wrap_c ? '0 : cyc_cnt + CYC_W'(1);
            if (tick_wrap_c) tick_cnt <= tick_cnt - TICK_W'(1);
            if (phase_end_c) begin
              if (beep_cnt > BEEP_W'(1)) begin
                beep_cnt <= beep_cnt - BEEP_W'(1);
                tick_cnt <= cfg_c.ticks;
                tone_cnt <= '0;
                buzzer   <= 1'b0;
                state    <= ST_ON;
              end else begin
                done  <= 1'b1;
                state <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy   <= 1'b0;
            buzzer <= 1'b1;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
